dmem_pipe: RTL
==============

# dmem_pipe

Parametrised data memory with a registered request/response handshake and a configurable access latency. It replaces the fixed single-cycle `dmem` behind the pipelined `Cpu` memory stage. The CPU derives its memory-stage stall from `req_ready`. Data width, address width, depth and latency are generics, so the same block serves the 8-bit core and wider successors.

## Interface
- `DATA_W`, 8: data word width in bits.
- `ADDR_W`, 8: address width in bits; one word per address.
- `DEPTH`, 256: implemented words, 1 ≤ DEPTH ≤ 2^ADDR_W.
- `LATENCY`, 1: cycles from request acceptance to response, 1..8.

- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: write data.
- `resp_valid` out 1: single-cycle response pulse.
- `resp_we` out 1: echo of `req_we` for this response.
- `resp_rdata` out DATA_W: read data. 0 for writes and for errors.
- `resp_err` out 1: the request address was ≥ DEPTH.

## Operation
- At most one request is outstanding. A request is accepted on the rising edge where `req_valid && req_ready`.
- FSM states:
  - IDLE: `req_ready=1`.
  - WAIT: counter running, `req_ready=0`.
  - RESP: `resp_valid=1`, `req_ready=1`.
- Transitions:
  - On accept with LATENCY=1, go to RESP.
  - On accept with LATENCY>1, go to WAIT with the counter at LATENCY-2.
  - In WAIT, decrement the counter; at 0, go to RESP.
  - From RESP: go to WAIT or RESP on a new accept, otherwise to IDLE.
- Array access happens at the accept edge:
  - A write updates the array at that edge.
  - A read snapshots the array into the response register at that edge.
  - Later writes do not alter an in-flight read response.
- Address check: if `req_addr ≥ DEPTH`, the write is dropped. The response carries `resp_err=1` and `resp_rdata=0`.
- A read accepted the cycle after a write to the same address returns the new data.
- `resp_we`, `resp_rdata` and `resp_err` are valid only while `resp_valid=1`. They are held at 0 otherwise.
- Array contents are not cleared by reset and are retained across reset.
- Reset is legal in any state:
  - The outstanding request is discarded and no response is issued.
  - A write already accepted before reset stays in the array.

## Timing
- Reset values: `req_ready=1`, `resp_valid=0`, `resp_we=0`, `resp_rdata=0`, `resp_err=0`, FSM=IDLE, counter=0.
- For a request accepted at edge k, `resp_valid` is high for exactly the cycle after edge k+LATENCY-1.
- LATENCY=1:
  - `req_ready` stays high permanently.
  - Back-to-back requests give one response per cycle, in order.
- LATENCY=N>1:
  - `req_ready` is low for N-1 cycles after acceptance.
  - Maximum throughput is one request per N cycles.
- The CPU stall term is `req_valid && !req_ready`. It is combinational from FSM state only; there is no path from `req_*` to `req_ready`.
- While `req_ready=0`, `req_valid` and the request fields are ignored. They are sampled again only when `req_ready=1`.
- The response register outputs are driven from flops, with no combinational read path to `resp_rdata`.

## Test plan
- Reset, LATENCY=1: write 0xA5 to addr 0x10, then read 0x10 on the next cycle. Required: two `resp_valid` pulses in consecutive cycles; the second has `resp_rdata=0xA5`, `resp_we=0`, `resp_err=0`.
- LATENCY=3: read addr 0x20 holding 0x3C with `req_valid` held high. Required: `req_ready` low for 2 cycles; `resp_valid` pulse 3 cycles after acceptance with data 0x3C; next acceptance in the same cycle as the response.
- DEPTH=128: write 0xFF to 0x90, then read 0x90. Required: both responses have `resp_err=1` and `resp_rdata=0`; a read of 0x10 (0x90 mod 128) is unchanged.
- In-flight isolation, LATENCY=4: read 0x05 (0x11). Required: response 0x11; a following read returns the newer value.
- Reset mid-op, LATENCY=4: accept a read, then assert `reset` low for one cycle in WAIT. Required: no `resp_valid`; after release all outputs are at reset values and `req_ready=1`; array contents intact.
- Random back-to-back mix of 500 requests at LATENCY=1 and LATENCY=5 against a scoreboard model. Required: zero data, order or `resp_err` mismatches.

Source files
------------

// File: rtl/dmem_pipe.sv
// dmem_pipe: parametrised data memory with a request/response handshake and a
// configurable access latency. The array is written or snapshotted at the accept edge.
module dmem_pipe #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_we,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]      CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;
  localparam logic [ADDR_W:0] DEPTH_L  = DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_pend_we;
  logic              r_pend_err;
  logic [DATA_W-1:0] r_pend_rdata;

  logic              r_resp_valid;
  logic              r_resp_we;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;

  logic              w_accept;
  logic              w_in_range;
  logic              w_wr_en;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rdata;

  // Ready is a pure decode of the FSM state, so the CPU stall has no req_* path
  assign req_ready = (r_state != S_WAIT);

  assign resp_valid = r_resp_valid;
  assign resp_we    = r_resp_we;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

  // Request decode: accept, range check and the read snapshot value
  always_comb begin
    w_in_range = ({1'b0, req_addr} < DEPTH_L);
    w_accept   = req_valid && req_ready && reset;
    w_wr_en    = w_accept && req_we && w_in_range;
    w_idx      = req_addr[IDX_W-1:0];
    if (!req_we && w_in_range) begin
      w_rdata = r_mem[w_idx];
    end else begin
      w_rdata = {DATA_W{1'b0}};
    end
  end

  // Array write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= req_wdata;
    end
  end

  // Handshake FSM with latency counter and registered response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_pend_we    <= 1'b0;
      r_pend_err   <= 1'b0;
      r_pend_rdata <= {DATA_W{1'b0}};
      r_resp_valid <= 1'b0;
      r_resp_we    <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= {DATA_W{1'b0}};
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_we    <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= {DATA_W{1'b0}};
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_accept) begin
            if (LATENCY == 1) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_we    <= req_we;
              r_resp_err   <= !w_in_range;
              r_resp_rdata <= w_rdata;
            end else begin
              r_state      <= S_WAIT;
              r_cnt        <= CNT_INIT;
              r_pend_we    <= req_we;
              r_pend_err   <= !w_in_range;
              r_pend_rdata <= w_rdata;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_we    <= r_pend_we;
            r_resp_err   <= r_pend_err;
            r_resp_rdata <= r_pend_rdata;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

endmodule
